spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Host-side SPI master feeding the AES SPI slave. Accepts a 128-bit message
//  and an Nk*32-bit key from the host, serialises both LSB-first on SIMO
//  in one encrypt frame (mode=0), then runs a decrypt frame (mode=1) that
//  shifts 128 result bits back in on SOMI and presents them as a word.
//  Single clock domain shared with the slave; sits directly upstream of it.
// PARAMETERS
//  Nk      4  key length in 32-bit words (4/6/8); key frame = Nk*32 bits
//  GAP_CYC 2  cycles CSS held high between encrypt and decrypt frames (>=1)
//  RX_LAT  1  cycles after CSS falls in decrypt frame before SOMI bit 0 valid
// PORTS
//  clk     in  1        system clock, all logic on rising edge
//  rst_n   in  1        synchronous reset, active low
//  start   in  1        request transfer; sampled only in IDLE
//  msg_in  in  128      plaintext, bit 0 sent first
//  key_in  in  Nk*32    cipher key, bit 0 sent first
//  SOMI    in  1        serial data from slave
//  CSS     out 1        chip select, active low
//  SIMO    out 1        serial data to slave
//  mode    out 1        0 = encrypt/load frame, 1 = decrypt/readback frame
//  busy    out 1        high from cycle after accepted start until done
//  done    out 1        one-cycle pulse, result valid
//  result  out 128      readback word, bit 0 = first SOMI bit sampled
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): CSS=1, SIMO=0, mode=0, busy=0, done=0,
//    result=0, counters=0, state=IDLE. Applies mid-frame: frame abandoned.
//  - All outputs registered; slave samples SIMO on the edge after it changes.
//  - States: IDLE -> TX_MSG -> TX_KEY -> GAP -> RX_WAIT -> RX -> DONE -> IDLE.
//  - IDLE: CSS=1, mode=0. start=1 latches msg_in/key_in into shift regs;
//    next cycle TX_MSG, busy=1. start while busy is ignored (no queueing).
//  - TX_MSG: CSS=0, mode=0, SIMO=msg_sr[0], shift right each cycle; exactly
//    128 cycles (bit counter 0..127), then TX_KEY.
//  - TX_KEY: CSS=0, mode=0, SIMO=key_sr[0], shift right; exactly Nk*32
//    cycles, then GAP. CSS never deasserts between message and key.
//  - GAP: CSS=1, SIMO=0, mode=1 from first GAP cycle; GAP_CYC cycles.
//  - RX_WAIT: CSS=0, mode=1, SOMI ignored for RX_LAT cycles.
//  - RX: CSS=0, mode=1; each cycle result_sr <= {SOMI, result_sr[127:1]};
//    exactly 128 samples, then DONE.
//  - DONE (1 cycle): CSS=1, mode=0, result<=result_sr, done=1, busy=0;
//    next cycle IDLE. A start in the DONE cycle is ignored.
//  - result holds its value until next DONE or reset; not updated mid-run.
//  - Latency: start accepted at cycle 0 -> done at cycle
//    1+128+Nk*32+GAP_CYC+RX_LAT+128+1 (Nk=4 defaults: 389).
//  - Counters sized for max(128, Nk*32) = 256; no wrap within a frame.
// TESTING
//  1 Nk=4, msg=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f,
//    slave model echoes msg on SOMI -> first SIMO bits 1,1,1,1 (0xf LSB-first),
//    CSS low 256 contiguous cycles, done at cycle 389, result==msg.
//  2 Same vectors with real AES slave (encrypt then inverse) -> result==msg.
//  3 Nk=8, key=000102..1f -> TX_KEY lasts 256 cycles, CSS low 384 contiguous
//    cycles in encrypt frame, done at cycle 517.
//  4 start pulsed at cycles 5 and 300 during run -> ignored, single done pulse,
//    busy never drops early.
//  5 rst_n low at cycle 150 (mid-key) -> next cycle CSS=1, busy=0, result=0;
//    fresh start afterwards completes normally.
//  6 SOMI stuck 1 -> result=ffff...ff; stuck 0 -> result=0; done width 1 cycle.

Source files
------------

// File: rtl/spi_master.sv
// Host-side SPI master for the AES slave: one encrypt frame shifting message then key
// out LSB-first on SIMO, then one decrypt frame collecting a 128-bit result from SOMI.
module spi_master #(
    parameter int Nk      = 4,
    parameter int GAP_CYC = 2,
    parameter int RX_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [127:0]      msg_in,
    input  logic [Nk*32-1:0]  key_in,
    input  logic              SOMI,
    output logic              CSS,
    output logic              SIMO,
    output logic              mode,
    output logic              busy,
    output logic              done,
    output logic [127:0]      result
);

    localparam int KEY_W = Nk * 32;
    localparam int CNT_W = 9;

    localparam logic [CNT_W-1:0] MSG_LAST  = CNT_W'(127);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RX_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_MSG,
        S_TX_KEY,
        S_GAP,
        S_RX_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       msg_sr_q, msg_sr_d;
    logic [KEY_W-1:0]   key_sr_q, key_sr_d;
    logic [127:0]       rx_sr_q, rx_sr_d;

    logic               css_q, css_d;
    logic               simo_q, simo_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [127:0]       result_q, result_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter restarts at zero on every state change, so each phase counts its own length.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start)              state_d = S_TX_MSG;
            S_TX_MSG:  if (cnt_q == MSG_LAST)  state_d = S_TX_KEY;
            S_TX_KEY:  if (cnt_q == KEY_LAST)  state_d = S_GAP;
            S_GAP:     if (cnt_q == GAP_LAST)  state_d = (RX_LAT == 0) ? S_RX : S_RX_WAIT;
            S_RX_WAIT: if (cnt_q == WAIT_LAST) state_d = S_RX;
            S_RX:      if (cnt_q == MSG_LAST)  state_d = S_DONE;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        msg_sr_q <= msg_sr_d;
        key_sr_q <= key_sr_d;
        rx_sr_q  <= rx_sr_d;
    end

    always_comb begin
        msg_sr_d = msg_sr_q;
        key_sr_d = key_sr_q;
        rx_sr_d  = rx_sr_q;
        if (state_q == S_IDLE && start) begin
            msg_sr_d = msg_in;
            key_sr_d = key_in;
            rx_sr_d  = '0;
        end
        if (state_q == S_TX_MSG) msg_sr_d = msg_sr_q >> 1;
        if (state_q == S_TX_KEY) key_sr_d = key_sr_q >> 1;
        if (state_q == S_RX)     rx_sr_d  = {SOMI, rx_sr_q[127:1]};
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        css_d    = 1'b1;
        simo_d   = 1'b0;
        mode_d   = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_d)
            S_IDLE:    busy_d = 1'b0;
            S_TX_MSG:  begin css_d = 1'b0; simo_d = msg_sr_d[0]; end
            S_TX_KEY:  begin css_d = 1'b0; simo_d = key_sr_d[0]; end
            S_GAP:     mode_d = 1'b1;
            S_RX_WAIT: begin css_d = 1'b0; mode_d = 1'b1; end
            S_RX:      begin css_d = 1'b0; mode_d = 1'b1; end
            S_DONE:    begin busy_d = 1'b0; done_d = 1'b1; result_d = rx_sr_d; end
            default:   busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            css_q    <= 1'b1;
            simo_q   <= 1'b0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            css_q    <= css_d;
            simo_q   <= simo_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign CSS    = css_q;
    assign SIMO   = simo_q;
    assign mode   = mode_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: Nk=4 and Nk=8 instances, each with an echo/stuck SOMI slave model.
// Latency is counted in clock cycles with the cycle presenting start counted as cycle 1.
module tb_spi_master;

    localparam int RX_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n, start4, start8;
    logic [127:0] msg;
    logic [255:0] key;
    logic         somi4, somi8;
    logic         css4, simo4, mode4, busy4, done4;
    logic         css8, simo8, mode8, busy8, done8;
    logic [127:0] result4, result8;

    spi_master #(.Nk(4), .GAP_CYC(2), .RX_LAT(RX_LAT)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .msg_in(msg), .key_in(key[127:0]),
        .SOMI(somi4), .CSS(css4), .SIMO(simo4), .mode(mode4), .busy(busy4),
        .done(done4), .result(result4)
    );

    spi_master #(.Nk(8), .GAP_CYC(2), .RX_LAT(RX_LAT)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .msg_in(msg), .key_in(key),
        .SOMI(somi8), .CSS(css8), .SIMO(simo8), .mode(mode8), .busy(busy8),
        .done(done8), .result(result8)
    );

    int checks = 0;
    int errors = 0;
    int somi_mode = 0;   // 0 echo message, 1 stuck high, 2 stuck low

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int           inst;
        logic [127:0] res;
        int           t0;
        int           lat;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    function automatic logic slave_bit(input int k, input int sm, input logic [383:0] tx);
        if (k < RX_LAT) return (sm == 1) ? 1'b0 : (sm == 2) ? 1'b1 : ~tx[0];
        if (sm == 1) return 1'b1;
        if (sm == 2) return 1'b0;
        return tx[k - RX_LAT];
    endfunction

    // Slave models: capture the encrypt frame, drive SOMI in the decrypt frame.
    logic [383:0] tx4, tx8;
    int txn4, txn8, rxk4, rxk8, run4, run8;

    always @(negedge clk) begin
        if (!rst_n) begin
            txn4 = 0; rxk4 = 0; run4 = 0; somi4 = 1'b0;
        end else begin
            if (!css4 && !mode4) begin
                if (txn4 < 384) tx4[txn4] = simo4;
                txn4++; run4++;
            end else if (run4 != 0) begin
                chk("enc_css_low_run4", 256'(run4), 256'd256);
                run4 = 0;
            end
            if (!css4 && mode4) begin
                somi4 = slave_bit(rxk4, somi_mode, tx4);
                rxk4++;
            end else rxk4 = 0;
            if (!busy4) txn4 = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            txn8 = 0; rxk8 = 0; run8 = 0; somi8 = 1'b0;
        end else begin
            if (!css8 && !mode8) begin
                if (txn8 < 384) tx8[txn8] = simo8;
                txn8++; run8++;
            end else if (run8 != 0) begin
                chk("enc_css_low_run8", 256'(run8), 256'd384);
                run8 = 0;
            end
            if (!css8 && mode8) begin
                somi8 = slave_bit(rxk8, somi_mode, tx8);
                rxk8++;
            end else rxk8 = 0;
            if (!busy8) txn8 = 0;
        end
    end

    // Scoreboard monitor.
    int   ndone = 0;
    logic done4_p = 1'b0, done8_p = 1'b0, busy4_p = 1'b0, busy8_p = 1'b0, rst_p = 1'b0;

    always @(negedge clk) begin
        if (done4 || done8) begin
            ndone++;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_inst", 256'(done8 ? 8 : 4), 256'(mon_e.inst));
                chk("result", 256'(done8 ? result8 : result4), 256'(mon_e.res));
                chk("latency", 256'(cyc - mon_e.t0 + 1), 256'(mon_e.lat));
            end
        end
        if (done4_p) chk("done4_width", 256'(done4), 256'd0);
        if (done8_p) chk("done8_width", 256'(done8), 256'd0);
        if (rst_n && rst_p && busy4_p && !busy4) chk("busy4_drop_at_done", 256'(done4), 256'd1);
        if (rst_n && rst_p && busy8_p && !busy8) chk("busy8_drop_at_done", 256'(done8), 256'd1);
        done4_p = done4; done8_p = done8; busy4_p = busy4; busy8_p = busy8; rst_p = rst_n;
    end

    task automatic issue(input int inst, input logic [127:0] exp_res, input int lat);
        @(negedge clk);
        if (inst == 8) start8 = 1'b1; else start4 = 1'b1;
        sb_q.push_back('{inst, exp_res, cyc, lat});
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (sb_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("run_completes", 256'(sb_q.size()), 256'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    localparam logic [127:0] MSG1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] MSG2 = 128'hfedcba98765432100f1e2d3c4b5a6978;
    localparam logic [127:0] KEY2 = 128'h55aa33cc0ff0f00f123456789abcdef0;
    localparam logic [255:0] KEY8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        int n;
        rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
        msg = '0; key = '0; somi_mode = 0;
        repeat (3) @(negedge clk);

        chk("rst_css4", 256'(css4), 256'd1);
        chk("rst_simo4", 256'(simo4), 256'd0);
        chk("rst_mode4", 256'(mode4), 256'd0);
        chk("rst_busy4", 256'(busy4), 256'd0);
        chk("rst_done4", 256'(done4), 256'd0);
        chk("rst_result4", 256'(result4), 256'd0);
        chk("rst_css8", 256'(css8), 256'd1);
        chk("rst_busy8", 256'(busy8), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Echo slave, Nk=4 defaults.
        msg = MSG1; key = {128'h0, KEY1};
        issue(4, MSG1, 389);
        wait_idle(600);
        chk("first_simo_bits", 256'(tx4[3:0]), 256'hf);
        chk("tx_msg_stream4", 256'(tx4[127:0]), 256'(MSG1));
        chk("tx_key_stream4", 256'(tx4[255:128]), 256'(KEY1));

        // Starts during the run and in the DONE cycle are ignored.
        issue(4, MSG1, 389);
        repeat (4) @(negedge clk);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        repeat (294) @(negedge clk);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        n = 0;
        while (!done4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen4", 256'(done4), 256'd1);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        chk("start_in_done_ignored", 256'(busy4), 256'd0);
        @(negedge clk);
        chk("still_idle", 256'(busy4), 256'd0);
        wait_idle(10);

        // SOMI stuck low, then stuck high.
        somi_mode = 2; msg = MSG2;
        issue(4, 128'h0, 389);
        wait_idle(600);
        somi_mode = 1;
        issue(4, {128{1'b1}}, 389);
        wait_idle(600);

        // Reset in the middle of the key phase.
        somi_mode = 0; msg = MSG1;
        issue(4, MSG1, 389);
        repeat (149) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_css", 256'(css4), 256'd1);
        chk("midrst_busy", 256'(busy4), 256'd0);
        chk("midrst_result", 256'(result4), 256'd0);
        chk("midrst_simo", 256'(simo4), 256'd0);
        chk("midrst_mode", 256'(mode4), 256'd0);
        chk("midrst_done", 256'(done4), 256'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh run after the abandoned frame.
        msg = MSG2; key = {128'h0, KEY2};
        issue(4, MSG2, 389);
        wait_idle(600);
        chk("tx_msg_stream4b", 256'(tx4[127:0]), 256'(MSG2));
        chk("tx_key_stream4b", 256'(tx4[255:128]), 256'(KEY2));

        // Nk=8 instance.
        msg = MSG1; key = KEY8;
        issue(8, MSG1, 517);
        wait_idle(800);
        chk("tx_msg_stream8", 256'(tx8[127:0]), 256'(MSG1));
        chk("tx_key_stream8", tx8[383:128], KEY8);

        chk("done_count", 256'(ndone), 256'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
